// File: rtl/board_move_sequencer.sv
// Board RAM sequencer: serves piece queries and moves from the game FSM and read-only scans from the VGA renderer.
// Latency: query done 3 cycles after accept, valid move 6, rejected move 4; renderer data 1 cycle after rd_gnt.
// Backpressure: commands seen while busy are dropped; renderer holds i_rd_req until o_rd_gnt (control wins ties).
// Optional build macro BMS_KING_WIN_EN adds o_game_won (set on king capture, blocks further moves).
module board_move_sequencer #(
  parameter int COORD_W   = 4,
  parameter int PIECE_W   = 4,
  parameter int KING_TYPE = 6
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_cmd_query,
  input  logic                   i_cmd_move,
  input  logic                   i_player,
  input  logic [COORD_W-1:0]     i_src_x,
  input  logic [COORD_W-1:0]     i_src_y,
  input  logic [COORD_W-1:0]     i_dst_x,
  input  logic [COORD_W-1:0]     i_dst_y,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [PIECE_W-1:0]     o_piece,
  output logic                   o_piece_own,
  output logic                   o_move_ok,
  output logic [PIECE_W-1:0]     o_captured,
  input  logic                   i_rd_req,
  input  logic [COORD_W-1:0]     i_rd_x,
  input  logic [COORD_W-1:0]     i_rd_y,
  output logic                   o_rd_gnt,
  output logic                   o_rd_valid,
  output logic [PIECE_W-1:0]     o_rd_data,
  output logic [2*COORD_W-1:0]   o_mem_addr,
  output logic                   o_mem_we,
  output logic [PIECE_W-1:0]     o_mem_wdata,
  input  logic [PIECE_W-1:0]     i_mem_rdata
`ifdef BMS_KING_WIN_EN
  ,
  output logic                   o_game_won
`endif
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_Q_RD,
    S_Q_LATCH,
    S_M_RD_SRC,
    S_M_RD_DST,
    S_M_CHECK,
    S_M_WR_DST,
    S_M_WR_SRC,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [COORD_W-1:0]     r_src_x;
  logic [COORD_W-1:0]     r_src_y;
  logic [COORD_W-1:0]     r_dst_x;
  logic [COORD_W-1:0]     r_dst_y;
  logic                   r_player;
  logic [PIECE_W-1:0]     r_piece;
  logic                   r_piece_own;
  logic                   r_move_ok;
  logic [PIECE_W-1:0]     r_captured;
  logic                   r_rd_valid;

  logic                   w_idle;
  logic                   w_move_en;
  logic                   w_accept_move;
  logic                   w_accept_query;
  logic                   w_rd_gnt;
  logic                   w_move_valid;
  logic [2*COORD_W-1:0]   w_src_addr;
  logic [2*COORD_W-1:0]   w_dst_addr;
  logic [2*COORD_W-1:0]   w_mem_addr;
  logic                   w_mem_we;
  logic [PIECE_W-1:0]     w_mem_wdata;

`ifdef BMS_KING_WIN_EN
  localparam logic [PIECE_W-2:0] LP_KING_TYPE = KING_TYPE[PIECE_W-2:0];
  logic                   r_game_won;

  // Once a king has fallen the board is frozen for moves; queries and scans still run.
  assign w_move_en = i_cmd_move && !r_game_won;

  // Latch the win when the piece being captured (already in r_captured) is a king.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_game_won <= 1'b0;
    end else if (r_state == S_M_WR_SRC && r_captured[PIECE_W-2:0] == LP_KING_TYPE) begin
      r_game_won <= 1'b1;
    end
  end

  assign o_game_won = r_game_won;
`else
  // King type only matters when the win option is built in.
  logic                   w_unused_king;
  assign w_unused_king = (KING_TYPE != 0);
  assign w_move_en     = i_cmd_move;
`endif

  assign w_idle         = (r_state == S_IDLE);
  assign w_accept_move  = w_idle && w_move_en;
  assign w_accept_query = w_idle && !w_move_en && i_cmd_query;
  // Renderer only gets the RAM in an otherwise quiet IDLE cycle.
  assign w_rd_gnt       = w_idle && i_rd_req && !i_cmd_move && !i_cmd_query && !i_reset;
  assign w_src_addr     = {r_src_y, r_src_x};
  assign w_dst_addr     = {r_dst_y, r_dst_x};

  // In M_CHECK r_piece holds the source code and i_mem_rdata the destination code.
  assign w_move_valid = (r_piece[PIECE_W-2:0] != '0) &&
                        (r_piece[PIECE_W-1] == r_player) &&
                        (w_src_addr != w_dst_addr) &&
                        ((i_mem_rdata[PIECE_W-2:0] == '0) || (i_mem_rdata[PIECE_W-1] != r_player));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and RAM port drive.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_addr  = '0;
    w_mem_we    = 1'b0;
    w_mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept_move) begin
          w_state_nxt = S_M_RD_SRC;
        end else if (w_accept_query) begin
          w_state_nxt = S_Q_RD;
        end else if (w_rd_gnt) begin
          w_mem_addr = {i_rd_y, i_rd_x};
        end
      end
      S_Q_RD: begin
        w_mem_addr  = w_src_addr;
        w_state_nxt = S_Q_LATCH;
      end
      S_Q_LATCH: begin
        w_state_nxt = S_DONE;
      end
      S_M_RD_SRC: begin
        w_mem_addr  = w_src_addr;
        w_state_nxt = S_M_RD_DST;
      end
      S_M_RD_DST: begin
        w_mem_addr  = w_dst_addr;
        w_state_nxt = S_M_CHECK;
      end
      S_M_CHECK: begin
        w_state_nxt = w_move_valid ? S_M_WR_DST : S_DONE;
      end
      S_M_WR_DST: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = w_dst_addr;
        w_mem_wdata = r_piece;
        w_state_nxt = S_M_WR_SRC;
      end
      S_M_WR_SRC: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = w_src_addr;
        w_mem_wdata = '0;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Command operands and result registers; results hold until the next accepted command.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_src_x     <= '0;
      r_src_y     <= '0;
      r_dst_x     <= '0;
      r_dst_y     <= '0;
      r_player    <= 1'b0;
      r_piece     <= '0;
      r_piece_own <= 1'b0;
      r_move_ok   <= 1'b0;
      r_captured  <= '0;
    end else begin
      if (w_accept_move || w_accept_query) begin
        r_src_x     <= i_src_x;
        r_src_y     <= i_src_y;
        r_dst_x     <= i_dst_x;
        r_dst_y     <= i_dst_y;
        r_player    <= i_player;
        r_piece_own <= 1'b0;
        r_move_ok   <= 1'b0;
        r_captured  <= '0;
      end
      case (r_state)
        S_Q_LATCH: begin
          r_piece     <= i_mem_rdata;
          r_piece_own <= (i_mem_rdata[PIECE_W-2:0] != '0) && (i_mem_rdata[PIECE_W-1] == r_player);
        end
        S_M_RD_DST: begin
          r_piece <= i_mem_rdata;
        end
        S_M_CHECK: begin
          if (w_move_valid) begin
            r_captured <= i_mem_rdata;
          end
        end
        S_M_WR_SRC: begin
          r_move_ok <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Renderer read data returns the cycle after the grant.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_gnt;
    end
  end

  assign o_busy      = !w_idle;
  assign o_done      = (r_state == S_DONE);
  assign o_piece     = r_piece;
  assign o_piece_own = r_piece_own;
  assign o_move_ok   = r_move_ok;
  assign o_captured  = r_captured;
  assign o_rd_gnt    = w_rd_gnt;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_valid ? i_mem_rdata : '0;
  assign o_mem_addr  = w_mem_addr;
  assign o_mem_we    = w_mem_we;
  assign o_mem_wdata = w_mem_wdata;

endmodule

// File: doc/board_move_sequencer.md
Name: board_move_sequencer

Overview:
- Owns the single-port board RAM (one word per square) and sequences every access to it.
- Serves two requesters. The game control FSM issues piece queries and moves; the VGA board renderer issues read-only scans.
- A move is executed as read-source, read-destination, check, write-destination, clear-source. The control FSM gets a done pulse carrying the validity and capture result.

Parameters:
- COORD_W, 4, width of each board coordinate. RAM address is {y,x}, 2*COORD_W bits.
- PIECE_W, 4, piece code width. Bit PIECE_W-1 is the owner (0 = player 0, 1 = player 1). The low PIECE_W-1 bits are the type; type 0 = empty square.
- KING_TYPE, 6, type code of the king. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_query  in  1  one-cycle request: read square (src_x,src_y)
- cmd_move  in  1  one-cycle request: move (src_x,src_y) to (dst_x,dst_y)
- player  in  1  current player; sampled when a command is accepted
- src_x, src_y  in  COORD_W each  source / query square
- dst_x, dst_y  in  COORD_W each  destination square
- busy  out  1  sequencer not IDLE
- done  out  1  one-cycle pulse when a command completes
- piece  out  PIECE_W  code read by the last query, or the source code of the last move
- piece_own  out  1  last query: square non-empty and owned by the player
- move_ok  out  1  last move passed the check and was written
- captured  out  PIECE_W  destination code overwritten by the last valid move (0 if the square was empty)
- rd_req  in  1  renderer read request
- rd_x, rd_y  in  COORD_W each  renderer square
- rd_gnt  out  1  renderer request accepted this cycle
- rd_valid  out  1  rd_data valid; one cycle after rd_gnt
- rd_data  out  PIECE_W  renderer read data
- mem_addr  out  2*COORD_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  PIECE_W  RAM write data
- mem_rdata  in  PIECE_W  RAM read data; synchronous, valid the cycle after the address

Behaviour:
- States: IDLE, Q_RD, Q_LATCH, M_RD_SRC, M_RD_DST, M_CHECK, M_WR_DST, M_WR_SRC, DONE.
- Reset: state=IDLE. busy, done, piece_own, move_ok, rd_gnt, rd_valid, mem_we = 0. piece, captured, rd_data, mem_addr, mem_wdata = 0.
- IDLE acceptance:
  - cmd_move has priority over cmd_query. If both are high, the move is taken and the query is dropped.
  - On acceptance, latch src, dst and player, then go to M_RD_SRC or Q_RD. piece_own, move_ok and captured clear on acceptance.
  - Commands arriving while busy=1 are ignored and not queued.
- Query: Q_RD drives mem_addr={src_y,src_x}. Q_LATCH sets piece=mem_rdata and piece_own=(type!=0 && owner==player). Then DONE. done asserts 3 cycles after the accept edge.
- Move sequence:
  - M_RD_SRC: mem_addr=src.
  - M_RD_DST: mem_addr=dst; latch piece=mem_rdata.
  - M_CHECK: the move is valid when all of these hold: piece type != 0; piece owner == player; src != dst; mem_rdata is empty, or its owner != player.
  - M_CHECK, valid: captured=mem_rdata, go to M_WR_DST.
  - M_CHECK, invalid: go to DONE with move_ok=0 and no RAM write.
  - M_WR_DST: mem_we=1, address dst, data piece.
  - M_WR_SRC: mem_we=1, address src, data 0; set move_ok=1.
  - DONE: done=1 for one cycle, then back to IDLE.
  - Latency: valid move, done 6 cycles after accept; invalid move, done 4 cycles after accept.
- mem_we is high only in M_WR_DST and M_WR_SRC.
- Renderer arbitration:
  - rd_gnt=1 (combinational) only when state==IDLE, rd_req=1, cmd_move=0 and cmd_query=0.
  - While rd_gnt=1, mem_addr={rd_y,rd_x}.
  - The next cycle, rd_valid=1 and rd_data=mem_rdata. rd_valid is registered.
  - While busy, the renderer is stalled with rd_gnt=0 and holds rd_req.
  - A control command in the same cycle as rd_req wins.
- piece, piece_own, move_ok and captured hold until the next accepted command.
- Coordinates are used unsigned and unmodified. The full 2^COORD_W grid is addressable.
- Reset mid-operation: IDLE on the next edge, with no further reads or writes. A destination write already done stays done; there is no rollback. No done pulse.

Optional Feature:
- Macro BMS_KING_WIN_EN adds output game_won (1 bit, reset 0).
- With the macro: game_won sets in M_WR_SRC when the captured type == KING_TYPE. It stays set until reset. While game_won=1, further cmd_move requests are ignored; queries and renderer reads continue.
- Without the macro: there is no game_won port and no capture-type decode.

Test Plan:
- Query: RAM[{2,3}]=4'h1, player=0, cmd_query at (3,2). Required: done on cycle +3, piece=1, piece_own=1. Same square with player=1: piece_own=0.
- Valid capture: src (1,1)=4'h2, dst (1,2)=4'hA, player=0. Required: mem_we on cycles +4/+5, RAM dst=2, RAM src=0, done on cycle +6, move_ok=1, captured=4'hA.
- Invalid moves: empty source; opponent's source piece; own piece on destination; src==dst. Each required: done on cycle +4, move_ok=0, mem_we never asserted, RAM unchanged.
- Arbitration:
  - rd_req held through a move: rd_gnt=0 while busy; first grant in the IDLE cycle after DONE; rd_valid next cycle with the updated square.
  - rd_req and cmd_query in the same cycle: query wins.
- Reset mid-move: reset asserted in M_WR_DST. Required: IDLE next cycle, dst written, src unchanged, no done, all outputs at reset values.
- BMS_KING_WIN_EN: capture 4'hE with player=0 and KING_TYPE=6. Required: game_won=1 after M_WR_SRC; a following cmd_move gives busy=0 and no done; a query still completes.
